// File: rtl/pixel_write_queue_pkg.sv
// Shared constants, pixel record and FSM encoding for the pixel write queue.
package pixel_write_queue_pkg;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int COORD_X_W = 9;
  localparam int COORD_Y_W = 8;
  localparam int COLOUR_W  = 3;
  localparam int PIX_W     = COORD_X_W + COORD_Y_W + COLOUR_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_X_W-1:0] x;
    logic [COORD_Y_W-1:0] y;
    logic [COLOUR_W-1:0]  colour;
  } pixel_t;
endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Small pixel FIFO, {x,y,colour} wide; pointers carry one wrap bit to tell full from empty.
module pixel_fifo
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push,
  input  pixel_t i_data,
  input  logic   i_pop,
  output pixel_t o_data,
  output logic   o_full,
  output logic   o_empty
);
  localparam int AW = $clog2(DEPTH);

  pixel_t         r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/pixel_write_queue.sv
// Clips sprite pixels, queues them towards the VGA adapter, and runs full-screen clears
// after draining the queue. Handshake: a pixel transfers on any rising edge with in_valid && in_ready.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int                   DEPTH     = 4,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = 3'b000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [COORD_X_W-1:0] in_x,
  input  logic [COORD_Y_W-1:0] in_y,
  input  logic [COLOUR_W-1:0]  in_colour,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear_req,
  output logic [COORD_X_W-1:0] vga_x,
  output logic [COORD_Y_W-1:0] vga_y,
  output logic [COLOUR_W-1:0]  vga_colour,
  output logic                 vga_plot,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [7:0]           drop_count,
  output state_t               dbg_state
);
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_accept;
  logic                 w_in_range;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_clear_start;
  logic                 w_clear_last;
  pixel_t               w_in_pix;
  pixel_t               w_fifo_out;
  pixel_t               r_vga_pix;
  logic                 r_vga_plot;
  logic [COORD_X_W-1:0] r_col;
  logic [COORD_Y_W-1:0] r_row;
  logic                 r_clear_req_q;
  logic                 r_clear_done;
  logic [7:0]           r_drop_count;

  assign w_in_pix      = '{x: in_x, y: in_y, colour: in_colour};
  assign w_accept      = in_valid && in_ready;
  assign w_in_range    = (in_x < COORD_X_W'(SCREEN_W)) && (in_y < COORD_Y_W'(SCREEN_H));
  assign w_push        = w_accept && w_in_range;
  // A level held high only starts one clear; it must drop before another is taken.
  assign w_clear_start = clear_req && !r_clear_req_q;
  assign w_clear_last  = (r_col == COORD_X_W'(SCREEN_W - 1)) && (r_row == COORD_Y_W'(SCREEN_H - 1));

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (w_in_pix),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_clear_start) w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_fifo_empty)  w_state_next = ST_CLEAR;
      ST_CLEAR: if (w_clear_last)  w_state_next = ST_RUN;
      default:                     w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == ST_RUN) && !w_fifo_full;
    clear_busy = (r_state != ST_RUN);
    w_pop      = (r_state != ST_CLEAR) && !w_fifo_empty;
    vga_x      = r_vga_pix.x;
    vga_y      = r_vga_pix.y;
    vga_colour = r_vga_pix.colour;
    vga_plot   = r_vga_plot;
    if (r_state == ST_CLEAR) begin
      vga_x      = r_col;
      vga_y      = r_row;
      vga_colour = BG_COLOUR;
      vga_plot   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vga_pix     <= '0;
      r_vga_plot    <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_clear_req_q <= 1'b0;
      r_clear_done  <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_clear_req_q <= clear_req;
      r_vga_plot    <= w_pop;
      if (w_pop) r_vga_pix <= w_fifo_out;
      if (w_accept && !w_in_range && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      r_clear_done <= (r_state == ST_CLEAR) && w_clear_last;
      if (r_state == ST_CLEAR) begin
        if (w_clear_last) begin
          r_col <= '0;
          r_row <= '0;
        end else if (r_col == COORD_X_W'(SCREEN_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign clear_done = r_clear_done;
  assign drop_count = r_drop_count;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: latency, streaming, clipping, clear sequencing and reset abort.
module tb_pixel_write_queue;
  import pixel_write_queue_pkg::*;

  localparam logic [2:0] BG = 3'b101;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       clear_req = 1'b0;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       clear_busy;
  logic       clear_done;
  logic [7:0] drop_count;
  state_t     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  pixel_write_queue #(.DEPTH(4), .BG_COLOUR(BG)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    in_x = x;
    in_y = y;
    in_colour = c;
    in_valid = 1'b1;
  endtask

  task automatic check_plot(input string tag, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    check({tag, "_plot"}, vga_plot, 1);
    check({tag, "_x"}, vga_x, x);
    check({tag, "_y"}, vga_y, y);
    check({tag, "_colour"}, vga_colour, c);
  endtask

  initial begin
    int seq_err;
    int plot_err;

    // Reset state
    tick();
    tick();
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_drop", drop_count, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", in_ready, 1);

    // Scenario 1: single pixel, two-cycle latency
    drive(9'd5, 8'd7, 3'b100);
    tick();
    in_valid = 1'b0;
    check("s1_plot_n", vga_plot, 0);
    tick();
    check_plot("s1", 9'd5, 8'd7, 3'b100);
    tick();
    check("s1_plot_after", vga_plot, 0);

    // Scenario 2: ten back-to-back pixels, no stall and no gaps
    seq_err = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        drive(9'(k * 3 + 1), 8'(k + 2), 3'(k));
        if (in_ready !== 1'b1) seq_err++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 1) begin
        if (vga_plot !== 1'b1 || vga_x !== 9'((k - 1) * 3 + 1) ||
            vga_y !== 8'(k + 1) || vga_colour !== 3'(k - 1)) seq_err++;
      end
    end
    check("s2_stream_errs", seq_err, 0);
    tick();
    check("s2_plot_after", vga_plot, 0);

    // Scenario 3: clipping and drop counter saturation
    drive(9'd320, 8'd0, 3'd1);
    tick();
    check("s3_plot_a", vga_plot, 0);
    drive(9'd0, 8'd240, 3'd2);
    tick();
    in_valid = 1'b0;
    check("s3_plot_b", vga_plot, 0);
    tick();
    check("s3_plot_c", vga_plot, 0);
    check("s3_drop2", drop_count, 2);
    drive(9'd319, 8'd239, 3'd7);
    tick();
    in_valid = 1'b0;
    tick();
    check_plot("s3_corner", 9'd319, 8'd239, 3'd7);
    check("s3_drop_corner", drop_count, 2);
    plot_err = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) drive(9'($urandom_range(320, 511)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      else            drive(9'($urandom_range(0, 319)), 8'($urandom_range(240, 255)), 3'($urandom_range(0, 7)));
      tick();
      if (i > 0 && vga_plot !== 1'b0) plot_err++;
      if (i == 99) check("s3_drop102", drop_count, 102);
    end
    in_valid = 1'b0;
    tick();
    check("s3_no_plots", plot_err, 0);
    check("s3_drop_sat", drop_count, 255);

    // Scenarios 4 and 5: clear with 3 queued pixels, extra clear_req mid-clear
    drive(9'd10, 8'd20, 3'd1);
    tick();
    drive(9'd11, 8'd21, 3'd2);
    tick();
    check_plot("s4_a", 9'd10, 8'd20, 3'd1);
    drive(9'd12, 8'd22, 3'd3);
    clear_req = 1'b1;
    tick();
    in_valid = 1'b0;
    clear_req = 1'b0;
    check_plot("s4_b", 9'd11, 8'd21, 3'd2);
    check("s4_flush_ready", in_ready, 0);
    check("s4_flush_busy", clear_busy, 1);
    tick();
    check_plot("s4_c", 9'd12, 8'd22, 3'd3);
    check("s4_flush_busy2", clear_busy, 1);
    tick();
    seq_err = 0;
    for (int j = 0; j < 76800; j++) begin
      if (vga_plot !== 1'b1 || vga_x !== 9'(j % 320) || vga_y !== 8'(j / 320) ||
          vga_colour !== BG || clear_done !== 1'b0 || clear_busy !== 1'b1 || in_ready !== 1'b0) seq_err++;
      if (j == 0)     check_plot("s4_first", 9'd0, 8'd0, BG);
      if (j == 76799) check_plot("s4_last", 9'd319, 8'd239, BG);
      clear_req = (j == 1000);
      tick();
    end
    clear_req = 1'b0;
    check("s4_clear_errs", seq_err, 0);
    check("s4_done_pulse", clear_done, 1);
    check("s4_ready_after", in_ready, 1);
    check("s4_busy_after", clear_busy, 0);
    check("s4_plot_after", vga_plot, 0);
    check("s4_drop_kept", drop_count, 255);
    tick();
    check("s4_done_once", clear_done, 0);
    check("s5_no_reclear", clear_busy, 0);
    tick();
    check("s5_no_reclear2", clear_busy, 0);

    // Scenario 6: reset in the middle of a clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("s6_flush_busy", clear_busy, 1);
    check("s6_flush_ready", in_ready, 0);
    tick();
    for (int j = 0; j < 500; j++) tick();
    check_plot("s6_mid", 9'd180, 8'd1, BG);
    #1 reset = 1'b1;
    #1;
    check("s6_rst_x", vga_x, 0);
    check("s6_rst_y", vga_y, 0);
    check("s6_rst_colour", vga_colour, 0);
    check("s6_rst_plot", vga_plot, 0);
    check("s6_rst_busy", clear_busy, 0);
    check("s6_rst_done", clear_done, 0);
    check("s6_rst_drop", drop_count, 0);
    tick();
    reset = 1'b0;
    seq_err = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (clear_done !== 1'b0 || in_ready !== 1'b1 || vga_plot !== 1'b0 || clear_busy !== 1'b0) seq_err++;
    end
    check("s6_after_release", seq_err, 0);

    // Queued pixel lost to reset is never plotted
    drive(9'd1, 8'd1, 3'd1);
    tick();
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    check("s7_lost_a", vga_plot, 0);
    tick();
    check("s7_lost_b", vga_plot, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pixel_write_queue.md
PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, at least 2).
REQ-002 The block SHALL have parameter BG_COLOUR, default 3'b000, meaning the colour written during a screen clear.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_x  input  9  pixel column from a sprite drawer.
REQ-006 in_y  input  8  pixel row.
REQ-007 in_colour  input  3  pixel colour.
REQ-008 in_valid  input  1  producer offers in_x, in_y and in_colour.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 clear_req  input  1  request a full-screen clear to BG_COLOUR.
REQ-011 vga_x  output  9  column to VGA adapter.
REQ-012 vga_y  output  8  row to VGA adapter.
REQ-013 vga_colour  output  3  colour to VGA adapter.
REQ-014 vga_plot  output  1  VGA adapter write enable.
REQ-015 clear_busy  output  1  high in FLUSH and CLEAR.
REQ-016 clear_done  output  1  one-cycle pulse when a clear completes.
REQ-017 drop_count  output  8  count of clipped pixels, saturating at 255.

Function
REQ-018 A transfer SHALL occur on a rising edge where in_valid and in_ready are both high; in_ready SHALL equal (state==RUN) && !fifo_full, combinationally.
REQ-019 A transferred pixel with in_x >= 320 or in_y >= 240 SHALL be discarded and not enqueued, and drop_count SHALL increment by 1 unless it is already 255.
REQ-020 A transferred in-range pixel SHALL be pushed into the FIFO.
REQ-021 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-022 In RUN and FLUSH, when the FIFO is non-empty, one entry SHALL be popped per cycle into registered vga_x, vga_y and vga_colour, with vga_plot=1 in the following cycle.
REQ-023 When the FIFO is empty in RUN or FLUSH, vga_plot SHALL be 0.
REQ-024 A pixel accepted into an empty FIFO at edge N SHALL have vga_plot=1 in the cycle after edge N+1, giving a latency of 2 cycles.
REQ-025 Pixels SHALL reach the VGA outputs in acceptance order.
REQ-026 The FSM SHALL have states RUN, FLUSH and CLEAR.
REQ-027 RUN->FLUSH SHALL occur on any edge where clear_req=1.
REQ-028 In FLUSH, in_ready SHALL be 0 and remaining entries SHALL drain per REQ-022.
REQ-029 FLUSH->CLEAR SHALL occur on the edge where the FIFO is empty and no pop is pending; if the FIFO is already empty, FLUSH SHALL last one cycle.
REQ-030 In CLEAR, a 9-bit column counter and an 8-bit row counter starting at (0,0) SHALL drive vga_x and vga_y, with vga_colour=BG_COLOUR and vga_plot=1 every cycle.
REQ-031 In CLEAR, the column SHALL wrap from 319 to 0 and the row SHALL then increment, giving exactly 76800 plots.
REQ-032 After the plot at (319,239), the FSM SHALL return to RUN, reset both counters to 0 and pulse clear_done for one cycle.
REQ-033 clear_req SHALL be ignored in FLUSH and CLEAR; a clear_req held high in RUN SHALL start only one clear per RUN entry.
REQ-034 drop_count SHALL be unaffected by clears.

Reset
REQ-035 While reset is asserted, the block SHALL hold state=RUN, the FIFO empty, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, clear_busy=0, clear_done=0, drop_count=0, and both clear counters 0.
REQ-036 Reset asserted mid-CLEAR or mid-FLUSH SHALL abort the operation without a clear_done pulse.
REQ-037 Queued pixels lost to reset SHALL NOT be plotted.

Structure
REQ-038 A shared package SHALL hold the constants SCREEN_W=320, SCREEN_H=240, COORD_X_W=9, COORD_Y_W=8, COLOUR_W=3, and the state encoding.
REQ-039 The FIFO SHALL be one sub-module, pixel_fifo, with 20-bit width {x,y,colour}, DEPTH entries, push, pop, full and empty.
REQ-040 The FSM, clipping and clear counters SHALL reside in the top module.

Verification
REQ-041 Scenario 1: push (5,7,3'b100) with an idle FIFO -> vga_plot=1 with (5,7,4) two cycles after acceptance, then vga_plot=0.
REQ-042 Scenario 2: in_valid held for 10 back-to-back pixels -> in_ready never drops (push/pop balance), and all 10 pixels are plotted in order with no gaps.
REQ-043 Scenario 3: push (320,0) and (0,240) -> nothing plotted and drop_count=2; 300 further out-of-range pushes -> drop_count=255.
REQ-044 Scenario 4: stall output by filling with clear_req while 3 entries are queued -> the 3 pixels plot first, then 76800 plots of BG_COLOUR from (0,0) to (319,239), one clear_done pulse, and in_ready=1 the next cycle.
REQ-045 Scenario 5: clear_req pulsed again at CLEAR cycle 1000 -> ignored, and the total number of clear plots stays 76800.
REQ-046 Scenario 6: reset asserted at CLEAR cycle 500 -> outputs immediately at reset values, no clear_done, and in_ready=1 after release.
